config_stream_loader: RTL and testbench
=======================================

// Module: config_stream_loader
// PURPOSE
//  Upstream feeder for the PE tile array's shared configuration bus. Accepts a word stream
//  (valid/ready), parses header, addr/data pairs and checksum, and drives
//  config_addr/config_data so each pair is presented to every tile for exactly one cycle.
//  Sits between the host or bitstream interface and the broadcast config_addr/config_data
//  nets feeding all pe_tile_* instances.
// PARAMETERS
//  MAGIC         16'hC0F1  required value of header[31:16]
//  IDLE_SECTION  16'h0000  config_addr[31:16] driven when no write is active; matches no section code
// PORTS
//  clk           in   1   clock
//  reset         in   1   asynchronous, active-low reset
//  clear         in   1   sync pulse: abort/restart, return to HDR
//  in_data       in   32  stream word
//  in_valid      in   1   in_data valid
//  in_ready      out  1   loader accepts word this cycle (transfer = valid & ready)
//  config_addr   out  32  {section[31:16], tile_id[15:0]} to tile array
//  config_data   out  32  config payload to tile array
//  busy          out  1   stream in progress (past header, before DONE/ERR)
//  done          out  1   sticky: stream completed, checksum good
//  error         out  1   sticky: bad magic or checksum mismatch
//  writes_done   out  16  count of pairs issued to the bus in current stream
// BEHAVIOUR
//  - Reset (reset=0, async): state=HDR; config_addr={IDLE_SECTION,16'h0}; config_data=0;
//    in_ready=0 during reset, 1 from first cycle after release; busy=done=error=0; writes_done=0.
//  - Stream format: header {MAGIC, N[15:0]}, then N x (addr word, data word), then checksum
//    word = XOR of every addr and data word (header excluded). N=0 is legal: header then checksum 0.
//  - FSM: HDR -> ADDR (magic ok, N>0) | CHK (magic ok, N=0) | ERR (magic bad);
//    ADDR -> DATA on accept (latch addr, XOR into running sum);
//    DATA -> ADDR, or CHK after Nth pair, on accept;
//    CHK -> DONE if word==sum, else ERR. DONE, ERR hold until clear.
//  - in_ready=1 in HDR/ADDR/DATA/CHK, 0 in DONE/ERR. No word is consumed in DONE/ERR.
//  - Bus write: data-word accept in cycle t -> config_addr=latched addr,
//    config_data=data word in cycle t+1 only. In cycle t+2 config_addr returns to
//    {IDLE_SECTION,16'h0} unless another write is issued (back-to-back pairs need two
//    transfers, so consecutive writes are at least 2 cycles apart). config_data holds its
//    last value when idle.
//  - writes_done increments in cycle t+1, alongside the bus write. It wraps modulo 2^16
//    and cannot exceed N.
//  - Checksum is verified after all writes have been applied. ERR does not roll back
//    configuration already written.
//  - in_valid low stalls any state indefinitely with no bus activity.
//  - busy=1 in ADDR/DATA/CHK.
//  - clear (any state, highest priority over an accept the same cycle): next cycle state=HDR,
//    sum=0, writes_done=0, done=error=0, config_addr idle. A write already registered for
//    the clear cycle still completes its one bus cycle.
//  - Reset mid-stream: immediate idle bus, partial stream discarded.
// STRUCTURE
//  - Shared include config_defs.vh: section codes CONFIG_SB=7, CONFIG_CB0=6, CONFIG_CB1=5,
//    CONFIG_CLB=4, IDLE_SECTION, MAGIC, state encodings.
//    Tiles and loader use the same section codes.
//  - Single module. No sub-module: FSM, 32-bit XOR accumulator, 16-bit pair counter and
//    output registers are all local.
// TESTING
//  1. Header C0F10001, addr 00070003, data 00000005, chk 00070006 -> one cycle with
//     config_addr=00070003 / config_data=5; done=1, writes_done=1, error=0.
//  2. Header C0F10000, chk 00000000 -> done=1, no bus write; chk 00000001 instead -> error=1.
//  3. Header DEAD0002 -> error=1 next cycle, in_ready=0, further words ignored until clear.
//  4. Three pairs with in_valid toggled randomly -> exactly 3 single-cycle writes in stream
//     order; idle section between writes; done=1.
//  5. clear asserted after first pair of N=2 -> writes_done=0, state HDR; new valid stream
//     completes with done=1.
//  6. reset=0 asserted between addr and data words -> outputs at reset values asynchronously;
//     no write issued for the pending addr.

Source files
------------

// File: rtl/config_stream_loader_pkg.sv
// Shared definitions for the configuration stream loader and the PE tiles.
// The tiles and the loader use the same section codes in config_addr[31:16].
// IDLE_SECTION matches no section, so the tiles ignore an idle bus.
// Also holds the loader state encoding and the checksum step helper.
package config_stream_loader_pkg;

  localparam logic [15:0] MAGIC        = 16'hC0F1;
  localparam logic [15:0] IDLE_SECTION = 16'h0000;

  localparam logic [15:0] CONFIG_SB  = 16'd7;
  localparam logic [15:0] CONFIG_CB0 = 16'd6;
  localparam logic [15:0] CONFIG_CB1 = 16'd5;
  localparam logic [15:0] CONFIG_CLB = 16'd4;

  localparam logic [31:0] IDLE_ADDR = {IDLE_SECTION, 16'h0000};

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Running stream checksum: XOR of every addr and data word.
  function automatic logic [31:0] checksum_step(input logic [31:0] sum,
                                                input logic [31:0] word);
    return sum ^ word;
  endfunction

endpackage

// File: rtl/config_stream_loader.sv
// config_stream_loader
// Parses a valid/ready word stream of the form
//   {MAGIC, N}, N x (addr, data), checksum
// and broadcasts each addr/data pair to the tile array for exactly one cycle.
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   clear        synchronous abort/restart pulse, returns to header parsing
//   in_data      stream word
//   in_valid     in_data valid
//   in_ready     loader accepts a word this cycle
//   config_addr  {section, tile_id} to the tile array (idle section when no write)
//   config_data  config payload (holds last value when idle)
//   busy         stream past header and not yet finished
//   done         sticky: stream completed with a good checksum
//   error        sticky: bad magic or checksum mismatch
//   writes_done  pairs issued to the bus in the current stream
module config_stream_loader
  import config_stream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] writes_done
);

  state_t      state_r;
  state_t      next_state_s;
  logic        accept_s;
  logic        in_ready_s;
  logic        busy_s;
  logic        done_s;
  logic        error_s;

  logic        in_ready_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
  logic [31:0] sum_r;
  logic [31:0] addr_r;
  logic [15:0] pairs_left_r;
  logic [15:0] writes_done_r;
  logic [31:0] config_addr_r;
  logic [31:0] config_data_r;

  assign accept_s = in_valid & in_ready_r;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; clear overrides any accept in the same cycle.
  always_comb begin
    next_state_s = state_r;
    if (clear) begin
      next_state_s = ST_HDR;
    end else if (accept_s) begin
      case (state_r)
        ST_HDR: begin
          if (in_data[31:16] != MAGIC) begin
            next_state_s = ST_ERR;
          end else if (in_data[15:0] == 16'h0000) begin
            next_state_s = ST_CHK;
          end else begin
            next_state_s = ST_ADDR;
          end
        end
        ST_ADDR: next_state_s = ST_DATA;
        ST_DATA: begin
          if (pairs_left_r == 16'd1) begin
            next_state_s = ST_CHK;
          end else begin
            next_state_s = ST_ADDR;
          end
        end
        ST_CHK: begin
          if (in_data == sum_r) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_ERR;
          end
        end
        default: next_state_s = state_r;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Status outputs decoded from the next state so they register alongside it.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    error_s    = 1'b0;
    case (next_state_s)
      ST_HDR:  in_ready_s = 1'b1;
      ST_ADDR,
      ST_DATA,
      ST_CHK: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      ST_DONE: done_s  = 1'b1;
      ST_ERR:  error_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Registered status flags; in_ready stays low while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
    end
  end

  // Datapath: checksum, pair counter, address latch and the one-cycle bus write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_r         <= 32'h0000_0000;
      addr_r        <= 32'h0000_0000;
      pairs_left_r  <= 16'h0000;
      writes_done_r <= 16'h0000;
      config_addr_r <= IDLE_ADDR;
      config_data_r <= 32'h0000_0000;
    end else if (clear) begin
      // A write already on the bus this cycle finishes; the next cycle is idle.
      sum_r         <= 32'h0000_0000;
      pairs_left_r  <= 16'h0000;
      writes_done_r <= 16'h0000;
      config_addr_r <= IDLE_ADDR;
    end else begin
      // Bus returns to idle unless a data word is accepted this cycle.
      config_addr_r <= IDLE_ADDR;
      if (accept_s) begin
        case (state_r)
          ST_HDR: begin
            pairs_left_r  <= in_data[15:0];
            sum_r         <= 32'h0000_0000;
            writes_done_r <= 16'h0000;
          end
          ST_ADDR: begin
            addr_r <= in_data;
            sum_r  <= checksum_step(sum_r, in_data);
          end
          ST_DATA: begin
            sum_r         <= checksum_step(sum_r, in_data);
            pairs_left_r  <= pairs_left_r - 16'd1;
            writes_done_r <= writes_done_r + 16'd1;
            config_addr_r <= addr_r;
            config_data_r <= in_data;
          end
          default: sum_r <= sum_r;
        endcase
      end else begin
        sum_r <= sum_r;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign writes_done = writes_done_r;
  assign config_addr = config_addr_r;
  assign config_data = config_data_r;

endmodule

// File: tb/tb_config_stream_loader.sv
module tb_config_stream_loader;
  import config_stream_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] writes_done;

  int          tests = 0;
  int          fails = 0;
  bit          rand_gaps = 1'b0;
  logic [63:0] bus_q[$];

  config_stream_loader dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .config_addr (config_addr),
    .config_data (config_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .writes_done (writes_done)
  );

  always #5 clk = ~clk;

  // Bus monitor: every non-idle cycle is one observed write.
  always @(negedge clk) begin
    if (reset && config_addr[31:16] != IDLE_SECTION) begin
      bus_q.push_back({config_addr, config_data});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int guard;
    if (rand_gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        cyc();
      end
    end
    in_data  = w;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      cyc();
      guard++;
    end
    if (!in_ready) begin
      check("send_timeout", {63'b0, in_ready}, 64'd1);
    end else begin
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  function automatic logic [15:0] rand_section();
    case ($urandom_range(0, 3))
      0:       return CONFIG_SB;
      1:       return CONFIG_CB0;
      2:       return CONFIG_CB1;
      default: return CONFIG_CLB;
    endcase
  endfunction

  initial begin
    logic [31:0] hdr;
    logic [31:0] sum;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] chk;
    logic [63:0] exp_q[$];
    int          n;
    int          kind;

    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;

    // Reset state
    #12;
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_addr", {32'b0, config_addr}, {32'b0, IDLE_ADDR});
    check("rst_data", {32'b0, config_data}, 64'd0);
    check("rst_flags", {61'b0, busy, done, error}, 64'd0);
    check("rst_wd", {48'b0, writes_done}, 64'd0);
    #10 reset = 1'b1;
    cyc();
    check("ready_after_rst", {63'b0, in_ready}, 64'd1);

    // Test 1: single pair, exact timing
    bus_q.delete();
    send_word(32'hC0F1_0001);
    check("t1_busy", {63'b0, busy}, 64'd1);
    send_word(32'h0007_0003);
    send_word(32'h0000_0005);
    check("t1_bus", {32'b0, config_addr} << 32 | {32'b0, config_data}, 64'h0007_0003_0000_0005);
    check("t1_wd", {48'b0, writes_done}, 64'd1);
    send_word(32'h0007_0006);
    check("t1_idle", {32'b0, config_addr}, {32'b0, IDLE_ADDR});
    check("t1_flags", {61'b0, busy, done, error}, 64'b010);
    check("t1_wd_end", {48'b0, writes_done}, 64'd1);
    check("t1_nwrites", 64'(bus_q.size()), 64'd1);
    check("t1_ready_done", {63'b0, in_ready}, 64'd0);
    pulse_clear();

    // Test 2: N=0 good, then bad checksum
    bus_q.delete();
    send_word(32'hC0F1_0000);
    send_word(32'h0000_0000);
    check("t2_done", {61'b0, busy, done, error}, 64'b010);
    pulse_clear();
    send_word(32'hC0F1_0000);
    send_word(32'h0000_0001);
    check("t2_err", {61'b0, busy, done, error}, 64'b001);
    check("t2_nwrites", 64'(bus_q.size()), 64'd0);
    pulse_clear();

    // Test 3: bad magic, further words ignored
    bus_q.delete();
    send_word(32'hDEAD_0002);
    check("t3_err", {61'b0, busy, done, error}, 64'b001);
    check("t3_ready", {63'b0, in_ready}, 64'd0);
    in_valid = 1'b1;
    in_data  = 32'h0007_0001;
    repeat (3) cyc();
    in_valid = 1'b0;
    check("t3_hold", {61'b0, busy, done, error, in_ready}, 64'b0010);
    check("t3_nwrites", 64'(bus_q.size()), 64'd0);
    pulse_clear();
    check("t3_cleared", {60'b0, busy, done, error, in_ready}, 64'b0001);

    // Test 5: clear after first pair of N=2
    bus_q.delete();
    send_word(32'hC0F1_0002);
    send_word(32'h0006_0010);
    send_word(32'h1234_5678);
    check("t5_wd1", {48'b0, writes_done}, 64'd1);
    clear = 1'b1;
    check("t5_write_in_clear", {32'b0, config_addr}, 64'h0006_0010);
    cyc();
    clear = 1'b0;
    check("t5_wd0", {48'b0, writes_done}, 64'd0);
    check("t5_idle", {32'b0, config_addr}, {32'b0, IDLE_ADDR});
    check("t5_state", {60'b0, busy, done, error, in_ready}, 64'b0001);
    send_word(32'hC0F1_0001);
    send_word(32'h0005_0002);
    send_word(32'h0000_00AA);
    send_word(32'h0005_00A8);
    check("t5_done", {61'b0, busy, done, error}, 64'b010);
    check("t5_nwrites", 64'(bus_q.size()), 64'd2);
    pulse_clear();

    // Tests 4 + random: streams with random valid gaps against a list model
    rand_gaps = 1'b1;
    for (int s = 0; s < 10; s++) begin
      n    = (s == 0) ? 3 : int'($urandom_range(1, 5));
      kind = (s == 0) ? 2 : int'($urandom_range(0, 3));
      exp_q.delete();
      sum = 32'h0;
      hdr = {(kind == 0) ? (MAGIC ^ 16'($urandom_range(1, 65535))) : MAGIC, 16'(n)};
      bus_q.delete();
      send_word(hdr);
      if (kind != 0) begin
        for (int p = 0; p < n; p++) begin
          a = {rand_section(), 16'($urandom)};
          d = $urandom;
          sum = sum ^ a ^ d;
          exp_q.push_back({a, d});
          send_word(a);
          send_word(d);
        end
        chk = (kind == 1) ? (sum ^ (32'h1 << $urandom_range(0, 31))) : sum;
        send_word(chk);
      end
      cyc();
      cyc();
      check($sformatf("rs%0d_nwrites", s), 64'(bus_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++) begin
        check($sformatf("rs%0d_w%0d", s, i), bus_q[i], exp_q[i]);
      end
      check($sformatf("rs%0d_flags", s), {61'b0, busy, done, error},
            (kind >= 2) ? 64'b010 : 64'b001);
      check($sformatf("rs%0d_wd", s), {48'b0, writes_done}, (kind == 0) ? 64'd0 : 64'(n));
      pulse_clear();
    end
    rand_gaps = 1'b0;

    // Test 6: reset between addr and data
    bus_q.delete();
    send_word(32'hC0F1_0001);
    send_word(32'h0004_0009);
    #2 reset = 1'b0;
    #1;
    check("t6_async", {28'b0, busy, done, error, in_ready, config_addr}, {32'b0, IDLE_ADDR});
    check("t6_wd", {48'b0, writes_done}, 64'd0);
    in_valid = 1'b1;
    in_data  = 32'h0000_0077;
    repeat (2) cyc();
    #2 reset = 1'b1;
    in_valid = 1'b0;
    cyc();
    cyc();
    check("t6_nwrites", 64'(bus_q.size()), 64'd0);
    check("t6_state", {60'b0, busy, done, error, in_ready}, 64'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
